alu_issue: RTL and testbench
============================

# alu_issue

The ALU execute-stage front end of the RV32I core. It accepts decoded OP/OP-IMM instructions from decode over a valid/ready handshake and encodes funct3/funct7 into the 4-bit ALU operation code. It selects and registers the ALU operands, then captures the combinational ALU result into an output register toward writeback. It is the encoding side of the ALU operation-code interface and owns the execute-stage pipeline registers and backpressure.

## Interface
Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  block accepts the instruction this cycle.
- in_opcode  in  7  instruction opcode. 0110011 = OP, 0010011 = OP-IMM.
- in_funct3  in  3  instruction funct3.
- in_funct7b5  in  1  instruction bit 30.
- in_rs1  in  32  rs1 register value.
- in_rs2  in  32  rs2 register value.
- in_imm  in  32  sign-extended I-immediate.
- alu_op  out  4  operation code to the ALU (registered).
- alu_op1  out  32  ALU operand 1 (registered).
- alu_op2  out  32  ALU operand 2 (registered).
- alu_result  in  32  combinational result from the ALU.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts the result.
- out_result  out  32  registered result.
- out_illegal  out  1  the instruction was not a legal OP/OP-IMM encoding.

## Operation
ALU operation-code encoding:
- AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001.
- All other codes are unused.

Encoding rules, by funct3:
- 000: ADD. OP with funct7b5=1 gives SUB. OP-IMM always gives ADD.
- 001: SLL.
- 010: SLT.
- 011: SLTU.
- 100: XOR.
- 101: SRL, or SRA when bit 30 is set. For OP this is funct7b5; for OP-IMM it is in_imm[10].
- 110: OR.
- 111: AND.

Operands:
- op1 = rs1.
- op2 = rs2 for OP.
- op2 = imm for OP-IMM, except shifts, where op2 = {27'b0, imm[4:0]}.

Illegal instructions:
- Covers any other opcode.
- Covers OP with funct7b5=1 and funct3 not in {000, 101}.
- Handling: alu_op=ADD, op1=op2=0, illegal flag carried alongside the instruction.
- The instruction still flows through and emerges with out_illegal=1 and out_result=0.
- Illegal instructions never stall or drop.

Pipeline, two registered stages:
- S1 is the issue register driving alu_*. It holds s1_valid and s1_illegal.
- S2 is the result register driving out_*.
- s2_load = s1_valid && (!out_valid || out_ready). S2 captures alu_result, forced to 0 when s1_illegal.
- in_ready = !s1_valid || s2_load. This is combinational from out_ready and state; there is no path from in_valid.
- S1 loads when in_valid && in_ready. Otherwise it clears valid if s2_load, or holds.
- A held S1 keeps alu_* stable, so the ALU result stays stable.

## Timing
Reset values:
- s1_valid=0, out_valid=0, out_illegal=0, out_result=0.
- alu_op=0010 (ADD), alu_op1=0, alu_op2=0.

Handshake and latency:
- An input accepted at edge N appears on alu_* after N and on out_* after N+1. Latency is 2 cycles.
- Throughput is 1/cycle while out_ready=1.
- Full condition: both stages valid and out_ready=0. in_ready=0, and all registers hold.
- Simultaneous events: out_ready=1 with both stages full means S2 takes S1, S1 takes the new input, and in_ready=1 in that same cycle.
- Ordering is strict FIFO. No instruction is duplicated or lost.
- out_valid, once high, stays high with stable out_result/out_illegal until out_ready=1.

Reset mid-operation:
- Both stages are invalidated at the next edge and in-flight instructions are discarded.
- in_ready=1 in the first cycle after reset.
- in_valid asserted during the reset cycle is ignored.

## Structure
- Package alu_pkg holds the ALU operation-code localparams (the list above) and the opcode constants OPC_OP and OPC_OPIMM. The ALU itself must import the same package so both sides share one encoding.
- One sub-module, alu_op_encode: combinational funct3/funct7b5/opcode/imm[10] to {alu_op, use_imm, is_shift, illegal}.
- The pipeline registers and handshake live in alu_issue.

## Test plan
The bench drives alu_result from a behavioural ALU model keyed on alu_op.
- ADD: OP funct3=000, funct7b5=0, rs1=5, rs2=7 -> alu_op=0010 one cycle after accept; out_result=12 and out_illegal=0 two cycles after accept.
- SUB: same with funct7b5=1 -> alu_op=0110, out_result=0xFFFFFFFE.
- SRAI: OP-IMM funct3=101, imm=0x405, rs1=0x80000000 -> alu_op=0111, alu_op2=5, out_result=0xFC000000.
- Backpressure: issue 4 back-to-back ADDs of distinct values while out_ready=0 for 4 cycles.
  - in_ready drops after 2 accepts.
  - out_* holds the first result.
  - On out_ready=1, all 4 results emerge in order, one per cycle, with no gaps.
- Illegal: opcode 1100011, and separately OP funct3=100 with funct7b5=1 -> out_illegal=1 and out_result=0 for each, in order with the surrounding legal ops.
- Reset mid-stream: assert rst with both stages full -> next cycle out_valid=0, alu_op=0010, in_ready=1. A following ADD 1+1 gives out_result=2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU operation-code encoding and RV32I opcode constants.
// Imported by both the issue stage and the ALU so the two sides agree on one encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

endpackage

// File: rtl/alu_op_encode.sv
// Combinational decode of opcode/funct3/funct7b5/imm[10] into the ALU op code,
// operand-select hints and the illegal-instruction flag.
module alu_op_encode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       imm10_i,
  output logic [3:0] alu_op_o,
  output logic       use_imm_o,
  output logic       is_shift_o,
  output logic       illegal_o
);

  logic is_op;
  logic is_opimm;
  logic alt;

  assign is_op    = (opcode_i == OPC_OP);
  assign is_opimm = (opcode_i == OPC_OPIMM);
  // Instruction bit 30 lives in funct7 for OP and in the immediate for OP-IMM.
  assign alt      = is_op ? funct7b5_i : imm10_i;

  always_comb begin
    alu_op_o   = ALU_ADD;
    use_imm_o  = 1'b0;
    is_shift_o = 1'b0;
    illegal_o  = 1'b0;
    if (!is_op && !is_opimm) begin
      illegal_o = 1'b1;
    end else begin
      use_imm_o = is_opimm;
      case (funct3_i)
        3'b000: alu_op_o = (is_op && funct7b5_i) ? ALU_SUB : ALU_ADD;
        3'b001: begin
          alu_op_o   = ALU_SLL;
          is_shift_o = 1'b1;
        end
        3'b010: alu_op_o = ALU_SLT;
        3'b011: alu_op_o = ALU_SLTU;
        3'b100: alu_op_o = ALU_XOR;
        3'b101: begin
          alu_op_o   = alt ? ALU_SRA : ALU_SRL;
          is_shift_o = 1'b1;
        end
        3'b110: alu_op_o = ALU_OR;
        default: alu_op_o = ALU_AND;
      endcase
      if (is_op && funct7b5_i && (funct3_i != 3'b000) && (funct3_i != 3'b101)) begin
        illegal_o = 1'b1;
      end
    end
    if (illegal_o) begin
      alu_op_o   = ALU_ADD;
      use_imm_o  = 1'b0;
      is_shift_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage front end: encodes the ALU op, registers operands (S1) and
// captures the ALU result (S2) toward writeback with full backpressure.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; a producer holding valid keeps its payload stable until that edge, and
  // ready never depends on the same interface's valid.

  logic [3:0]      enc_alu_op;
  logic            enc_use_imm;
  logic            enc_is_shift;
  logic            enc_illegal;

  logic            s1_valid_q,   s1_valid_d;
  logic            s1_illegal_q, s1_illegal_d;
  logic [3:0]      alu_op_q,     alu_op_d;
  logic [XLEN-1:0] alu_op1_q,    alu_op1_d;
  logic [XLEN-1:0] alu_op2_q,    alu_op2_d;
  logic            out_valid_q,  out_valid_d;
  logic            out_illegal_q, out_illegal_d;
  logic [XLEN-1:0] out_result_q, out_result_d;

  logic            s2_load;
  logic            s1_load;
  logic [XLEN-1:0] op2_sel;

  alu_op_encode u_encode (
    .opcode_i   (in_opcode),
    .funct3_i   (in_funct3),
    .funct7b5_i (in_funct7b5),
    .imm10_i    (in_imm[10]),
    .alu_op_o   (enc_alu_op),
    .use_imm_o  (enc_use_imm),
    .is_shift_o (enc_is_shift),
    .illegal_o  (enc_illegal)
  );

  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;

  always_comb begin
    op2_sel = in_rs2;
    if (enc_illegal) begin
      op2_sel = '0;
    end else if (enc_use_imm) begin
      op2_sel = enc_is_shift ? {{(XLEN-5){1'b0}}, in_imm[4:0]} : in_imm;
    end
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_illegal_d  = s1_illegal_q;
    alu_op_d      = alu_op_q;
    alu_op1_d     = alu_op1_q;
    alu_op2_d     = alu_op2_q;
    out_valid_d   = out_valid_q;
    out_illegal_d = out_illegal_q;
    out_result_d  = out_result_q;

    // S1 operand registers only move on a load so the ALU output stays stable while held.
    if (s1_load) begin
      s1_valid_d   = 1'b1;
      s1_illegal_d = enc_illegal;
      alu_op_d     = enc_alu_op;
      alu_op1_d    = enc_illegal ? '0 : in_rs1;
      alu_op2_d    = op2_sel;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      out_valid_d   = 1'b1;
      out_illegal_d = s1_illegal_q;
      out_result_d  = s1_illegal_q ? '0 : alu_result;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_illegal_q  <= 1'b0;
      alu_op_q      <= ALU_ADD;
      alu_op1_q     <= '0;
      alu_op2_q     <= '0;
      out_valid_q   <= 1'b0;
      out_illegal_q <= 1'b0;
      out_result_q  <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_illegal_q  <= s1_illegal_d;
      alu_op_q      <= alu_op_d;
      alu_op1_q     <= alu_op1_d;
      alu_op2_q     <= alu_op2_d;
      out_valid_q   <= out_valid_d;
      out_illegal_q <= out_illegal_d;
      out_result_q  <= out_result_d;
    end
  end

  assign alu_op      = alu_op_q;
  assign alu_op1     = alu_op1_q;
  assign alu_op2     = alu_op2_q;
  assign out_valid   = out_valid_q;
  assign out_illegal = out_illegal_q;
  assign out_result  = out_result_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: behavioural ALU on alu_*, hand-computed
// expectations, scoreboard queue for the ordered result stream.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic [3:0]  alu_op;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_illegal;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];

  alu_issue #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .alu_op      (alu_op),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_illegal (out_illegal)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      ALU_AND:  alu_result = alu_op1 & alu_op2;
      ALU_OR:   alu_result = alu_op1 | alu_op2;
      ALU_ADD:  alu_result = alu_op1 + alu_op2;
      ALU_XOR:  alu_result = alu_op1 ^ alu_op2;
      ALU_SLL:  alu_result = alu_op1 << alu_op2[4:0];
      ALU_SRL:  alu_result = alu_op1 >> alu_op2[4:0];
      ALU_SUB:  alu_result = alu_op1 - alu_op2;
      ALU_SRA:  alu_result = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
      ALU_SLT:  alu_result = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
      ALU_SLTU: alu_result = {31'b0, alu_op1 < alu_op2};
      default:  alu_result = 32'h0;
    endcase
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7b5,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [32:0] exp_out);
    in_valid    = 1'b1;
    in_opcode   = opc;
    in_funct3   = f3;
    in_funct7b5 = f7b5;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    exp_q.push_back(exp_out);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    #1;
  endtask

  // Scoreboard / checks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed out_valid=%0b expected no pending result", tag, out_valid);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"},   {31'b0, out_valid},   32'd1);
      check({tag, "_result"},  out_result,           e[31:0]);
      check({tag, "_illegal"}, {31'b0, out_illegal}, {31'b0, e[32]});
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = 7'h0; in_funct3 = 3'h0; in_funct7b5 = 1'b0;
    in_rs1 = 32'h0; in_rs2 = 32'h0; in_imm = 32'h0;
    tick(); tick();
    rst = 1'b0; #1;

    // Reset state
    check("rst_out_valid",   {31'b0, out_valid},   32'd0);
    check("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
    check("rst_out_result",  out_result,           32'h0);
    check("rst_alu_op",      {28'b0, alu_op},      32'h2);
    check("rst_alu_op1",     alu_op1,              32'h0);
    check("rst_alu_op2",     alu_op2,              32'h0);
    check("rst_in_ready",    {31'b0, in_ready},    32'd1);

    // ADD 5+7
    drive(OPC_OP, 3'b000, 1'b0, 32'd5, 32'd7, 32'h0, {1'b0, 32'd12});
    tick(); idle();
    check("add_alu_op",  {28'b0, alu_op}, 32'h2);
    check("add_alu_op1", alu_op1, 32'd5);
    check("add_alu_op2", alu_op2, 32'd7);
    tick();
    expect_out("add_out");

    // SUB 5-7
    drive(OPC_OP, 3'b000, 1'b1, 32'd5, 32'd7, 32'h0, {1'b0, 32'hFFFF_FFFE});
    tick(); idle();
    check("sub_alu_op", {28'b0, alu_op}, 32'h6);
    tick();
    expect_out("sub_out");

    // SRAI 0x80000000 >>> 5
    drive(OPC_OPIMM, 3'b101, 1'b0, 32'h8000_0000, 32'h0, 32'h0000_0405, {1'b0, 32'hFC00_0000});
    tick(); idle();
    check("srai_alu_op",  {28'b0, alu_op}, 32'h7);
    check("srai_alu_op2", alu_op2, 32'd5);
    tick();
    expect_out("srai_out");
    tick();
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: four back-to-back ADDs while writeback stalls
    out_ready = 1'b0;
    drive(OPC_OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'h0, {1'b0, 32'd2});
    check("bp_ready_a", {31'b0, in_ready}, 32'd1);
    tick();
    drive(OPC_OP, 3'b000, 1'b0, 32'd2, 32'd2, 32'h0, {1'b0, 32'd4});
    check("bp_ready_b", {31'b0, in_ready}, 32'd1);
    tick();
    drive(OPC_OP, 3'b000, 1'b0, 32'd3, 32'd3, 32'h0, {1'b0, 32'd6});
    check("bp_ready_full", {31'b0, in_ready}, 32'd0);
    check("bp_hold1_result", out_result, 32'd2);
    tick();
    check("bp_hold2_ready", {31'b0, in_ready}, 32'd0);
    check("bp_hold2_result", out_result, 32'd2);
    check("bp_hold2_alu_op1", alu_op1, 32'd2);
    tick();
    check("bp_hold3_valid", {31'b0, out_valid}, 32'd1);
    check("bp_hold3_result", out_result, 32'd2);
    out_ready = 1'b1; #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    expect_out("bp_out_a");
    tick();
    expect_out("bp_out_b");
    drive(OPC_OP, 3'b000, 1'b0, 32'd4, 32'd4, 32'h0, {1'b0, 32'd8});
    tick();
    expect_out("bp_out_c");
    idle();
    tick();
    expect_out("bp_out_d");
    tick();
    check("bp_drain_valid", {31'b0, out_valid}, 32'd0);

    // Illegal encodings interleaved with legal ops
    drive(OPC_OP, 3'b000, 1'b0, 32'd10, 32'd20, 32'h0, {1'b0, 32'd30});
    tick();
    check("ill_l1_alu_op", {28'b0, alu_op}, 32'h2);
    drive(7'b1100011, 3'b000, 1'b0, 32'h1234, 32'h5678, 32'h0, {1'b1, 32'h0});
    tick();
    expect_out("ill_l1_out");
    check("ill_i1_alu_op",  {28'b0, alu_op}, 32'h2);
    check("ill_i1_alu_op1", alu_op1, 32'h0);
    check("ill_i1_alu_op2", alu_op2, 32'h0);
    drive(OPC_OP, 3'b100, 1'b1, 32'h00FF, 32'h0F0F, 32'h0, {1'b1, 32'h0});
    tick();
    expect_out("ill_i1_out");
    check("ill_i2_alu_op",  {28'b0, alu_op}, 32'h2);
    check("ill_i2_alu_op1", alu_op1, 32'h0);
    drive(OPC_OPIMM, 3'b000, 1'b0, 32'd100, 32'h0, 32'hFFFF_FFFF, {1'b0, 32'd99});
    tick();
    expect_out("ill_i2_out");
    idle();
    tick();
    expect_out("ill_l2_out");
    tick();

    // Reset with both stages full
    out_ready = 1'b0;
    drive(OPC_OP, 3'b000, 1'b0, 32'd9, 32'd9, 32'h0, {1'b0, 32'd18});
    tick();
    drive(OPC_OP, 3'b000, 1'b0, 32'd8, 32'd8, 32'h0, {1'b0, 32'd16});
    tick();
    check("mid_full_ready", {31'b0, in_ready}, 32'd0);
    exp_q.delete();
    rst = 1'b1;
    in_valid = 1'b1; in_funct7b5 = 1'b1; in_rs1 = 32'd50; in_rs2 = 32'd3;
    tick();
    rst = 1'b0; idle();
    check("mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_alu_op",    {28'b0, alu_op},    32'h2);
    check("mid_alu_op1",   alu_op1,            32'h0);
    check("mid_in_ready",  {31'b0, in_ready},  32'd1);
    out_ready = 1'b1;
    drive(OPC_OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'h0, {1'b0, 32'd2});
    tick(); idle();
    tick();
    expect_out("mid_after_add");
    tick();
    check("mid_drain_valid", {31'b0, out_valid}, 32'd0);
    check("end_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
